draw_frame_scheduler: RTL and testbench
=======================================

Name: draw_frame_scheduler

Overview:
- Sequences per-game-tick redraw of the VGA framebuffer's single pixel-write port among NUM_CLIENTS drawing engines: clear, pipe1, pipe2, bird, in fixed index order.
- On each rising edge of the game tick, starts each enabled client in turn, waits for its done, and muxes only that client's pixel stream onto the framebuffer port.
- Sits between the draw engines and VGA_framebuffer, replacing ad-hoc clear_en/clear_done locking in the top level.

Parameters:
- NUM_CLIENTS, 4: number of drawing clients; index 0 is drawn first.
- COORD_W, 11: width of x/y coordinates.
- TIMEOUT_CYCLES, 400000: maximum WAIT cycles per client before the watchdog aborts that client.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  game clock level (divided counter bit, same clk domain); edge-detected internally.
- client_en  in  NUM_CLIENTS  per-client enable; a disabled client is skipped.
- client_start  out  NUM_CLIENTS  one-cycle start pulse to the selected client.
- client_done  in  NUM_CLIENTS  client finished; sampled only for the selected client.
- client_x  in  NUM_CLIENTS*COORD_W  packed pixel x per client.
- client_y  in  NUM_CLIENTS*COORD_W  packed pixel y per client.
- client_color  in  NUM_CLIENTS  pixel color per client.
- client_wr  in  NUM_CLIENTS  pixel write strobe per client.
- fb_x  out  COORD_W  framebuffer x.
- fb_y  out  COORD_W  framebuffer y.
- fb_color  out  1  framebuffer color.
- fb_write  out  1  framebuffer write strobe.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame's sequence completes.
- timeout_flag  out  1  sticky; set when any client times out.
- dropped_ticks  out  8  saturating count of tick rises that arrive while busy.
- last_frame_cycles  out  24  frame duration in cycles (see Optional Feature).

Behaviour:
- Reset (async): all outputs 0, state=IDLE, idx=0, tick_q=0, watchdog=0.
- Tick edge: tick_q <= tick each cycle; rise = tick & ~tick_q.
- States: IDLE, START, WAIT, NEXT, FINISH.
- IDLE:
  - On rise, idx <= lowest enabled index, then go to START.
  - If no client is enabled, go directly to FINISH.
- START:
  - client_start[idx]=1 for exactly this cycle; watchdog <= 0; go to WAIT.
  - client_done is ignored in START.
- WAIT:
  - Registered mux: fb_x/fb_y/fb_color/fb_write <= client idx fields on the next cycle (1-cycle latency).
  - client_done[idx]=1: go to NEXT.
  - Else if watchdog == TIMEOUT_CYCLES-1: set timeout_flag and go to NEXT.
  - Else watchdog increments.
  - done from non-selected clients is ignored.
- NEXT:
  - idx <= next enabled index greater than idx, then go to START.
  - If there is none, go to FINISH.
  - client_en is sampled here, so enable changes mid-frame take effect for later indices only.
- FINISH: frame_done=1 for one cycle; go to IDLE.
- fb_write is 0 in every cycle whose previous-cycle state was not WAIT.
  - A pixel presented in the done cycle is still forwarded.
  - No pixel from another client ever reaches the port.
- A rise while state != IDLE does not restart the sequence; dropped_ticks increments and saturates at 255.
- A rise in the same cycle as FINISH counts as dropped.
- timeout_flag and dropped_ticks clear only on reset.
- Mid-frame reset: client_start drops and fb_write=0 immediately (async); clients must reset on the same signal.

Optional Feature:
- Macro DRAW_PERF_EN.
- Defined: a 24-bit counter runs from the IDLE→START/FINISH transition to FINISH, saturating at 2^24-1. last_frame_cycles is loaded in FINISH and holds until the next FINISH.
- Undefined: last_frame_cycles is tied to 0 and no counter is synthesized.

Decomposition:
- Package draw_sched_pkg:
  - sched_state_t enum.
  - COORD_W default.
  - Client index constants: CLIENT_CLEAR=0, CLIENT_PIPE1=1, CLIENT_PIPE2=2, CLIENT_BIRD=3.
- Sub-module next_client_finder: combinational; inputs client_en, current idx and a first-search flag; outputs next_idx and none_found. Used by both IDLE and NEXT.

Test Plan:
- All 4 clients enabled, each asserts done 10 cycles after its start → starts at 0,1,2,3 in order, each one cycle; frame_done pulses once; busy low afterwards.
- client_en=4'b1010 → starts only clients 1 and 3; client 0 pixels with client_wr=1 never appear on fb_write.
- Client 2 never asserts done, TIMEOUT_CYCLES=50 → after 50 WAIT cycles timeout_flag=1, client 3 starts, frame_done pulses.
- 300 tick rises while a client stalls (done withheld, large timeout) → dropped_ticks=255 (saturates); the sequence is not restarted.
- Client 1 drives x=100, y=50, color=1, wr=1 in WAIT → next cycle fb_x=100, fb_y=50, fb_color=1, fb_write=1; done in the same cycle as a pixel → that pixel is still written.
- Reset asserted in WAIT of client 2 → all outputs 0 asynchronously; the next rise restarts at client 0. With DRAW_PERF_EN, a 4×10-cycle frame gives last_frame_cycles equal to the measured total.

Source files
------------

// File: rtl/draw_frame_scheduler_pkg.sv
// Shared types and constants for the per-tick draw scheduler.
// The optional frame-duration counter is enabled with the DRAW_PERF_EN macro
// (see draw_frame_scheduler.sv).
package draw_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } sched_state_t;

  localparam int DEFAULT_COORD_W = 11;
  localparam int PERF_W          = 24;

  // Client slots, drawn in ascending index order.
  localparam int CLIENT_CLEAR = 0;
  localparam int CLIENT_PIPE1 = 1;
  localparam int CLIENT_PIPE2 = 2;
  localparam int CLIENT_BIRD  = 3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/draw_frame_scheduler_next_client_finder.sv
// Picks the next enabled client: the lowest enabled index when first_i is
// set, otherwise the lowest enabled index strictly above cur_idx_i.
module next_client_finder #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_CLIENTS-1:0] client_en_i,
  input  logic [IDX_W-1:0]       cur_idx_i,
  input  logic                   first_i,
  output logic [IDX_W-1:0]       next_idx_o,
  output logic                   none_found_o
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    next_idx_o   = '0;
    none_found_o = 1'b1;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (client_en_i[i] && (first_i || (i > int'(cur_idx_i)))) begin
        next_idx_o   = IDX_W'(i);
        none_found_o = 1'b0;
      end else begin
        next_idx_o   = next_idx_o;
        none_found_o = none_found_o;
      end
    end
  end

endmodule

// File: rtl/draw_frame_scheduler.sv
// Per-game-tick redraw sequencer: on each tick rise, starts every enabled
// client in index order, waits for its done (or a watchdog expiry) and
// forwards only the active client's pixel stream to the framebuffer port.
// Optional macro DRAW_PERF_EN adds a saturating frame-length counter that
// drives last_frame_cycles; without it that output is tied to zero.
module draw_frame_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int COORD_W        = DEFAULT_COORD_W,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic [NUM_CLIENTS-1:0]         client_en,
  output logic [NUM_CLIENTS-1:0]         client_start,
  input  logic [NUM_CLIENTS-1:0]         client_done,
  input  logic [NUM_CLIENTS*COORD_W-1:0] client_x,
  input  logic [NUM_CLIENTS*COORD_W-1:0] client_y,
  input  logic [NUM_CLIENTS-1:0]         client_color,
  input  logic [NUM_CLIENTS-1:0]         client_wr,
  output logic [COORD_W-1:0]             fb_x,
  output logic [COORD_W-1:0]             fb_y,
  output logic                           fb_color,
  output logic                           fb_write,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           timeout_flag,
  output logic [7:0]                     dropped_ticks,
  output logic [PERF_W-1:0]              last_frame_cycles
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]        WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CLIENTS-1:0] START_ONE = NUM_CLIENTS'(1);

  sched_state_t             state_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     tick_q;
  logic [WD_W-1:0]          wd_q;
  logic [NUM_CLIENTS-1:0]   client_start_q;
  logic [COORD_W-1:0]       fb_x_q;
  logic [COORD_W-1:0]       fb_y_q;
  logic                     fb_color_q;
  logic                     fb_write_q;
  logic                     busy_q;
  logic                     frame_done_q;
  logic                     timeout_q;
  logic [7:0]               dropped_q;

  logic                     rise_s;
  logic [IDX_W-1:0]         next_idx_s;
  logic                     none_s;
  logic [COORD_W-1:0]       sel_x_s;
  logic [COORD_W-1:0]       sel_y_s;

  assign rise_s  = tick & ~tick_q;
  assign sel_x_s = client_x[int'(idx_q)*COORD_W +: COORD_W];
  assign sel_y_s = client_y[int'(idx_q)*COORD_W +: COORD_W];

  // IDLE searches from the bottom; NEXT searches above the current client.
  next_client_finder #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_finder (
    .client_en_i  (client_en),
    .cur_idx_i    (idx_q),
    .first_i      (state_q == S_IDLE),
    .next_idx_o   (next_idx_s),
    .none_found_o (none_s)
  );

  // Sequencer FSM with registered pixel mux, status and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tick_q         <= 1'b0;
      wd_q           <= '0;
      client_start_q <= '0;
      fb_x_q         <= '0;
      fb_y_q         <= '0;
      fb_color_q     <= 1'b0;
      fb_write_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_q      <= 1'b0;
      dropped_q      <= 8'd0;
    end else begin
      tick_q         <= tick;
      client_start_q <= '0;
      frame_done_q   <= 1'b0;

      // A rise outside IDLE (FINISH included) never restarts the frame.
      if (rise_s && (state_q != S_IDLE)) begin
        dropped_q <= sat_inc8(dropped_q);
      end

      // Only the client being waited on may reach the port, one cycle later.
      if (state_q == S_WAIT) begin
        fb_x_q     <= sel_x_s;
        fb_y_q     <= sel_y_s;
        fb_color_q <= client_color[idx_q];
        fb_write_q <= client_wr[idx_q];
      end else begin
        fb_write_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (rise_s) begin
            busy_q <= 1'b1;
            if (none_s) begin
              state_q      <= S_FINISH;
              frame_done_q <= 1'b1;
            end else begin
              idx_q          <= next_idx_s;
              client_start_q <= START_ONE << next_idx_s;
              state_q        <= S_START;
            end
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (client_done[idx_q]) begin
            state_q <= S_NEXT;
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_NEXT;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (none_s) begin
            state_q      <= S_FINISH;
            frame_done_q <= 1'b1;
          end else begin
            idx_q          <= next_idx_s;
            client_start_q <= START_ONE << next_idx_s;
            state_q        <= S_START;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign client_start  = client_start_q;
  assign fb_x          = fb_x_q;
  assign fb_y          = fb_y_q;
  assign fb_color      = fb_color_q;
  assign fb_write      = fb_write_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign timeout_flag  = timeout_q;
  assign dropped_ticks = dropped_q;

`ifdef DRAW_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q;
  logic [PERF_W-1:0] last_cycles_q;

  // Count START/WAIT/NEXT cycles of the frame; publish the total in FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt_q    <= '0;
      last_cycles_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:   perf_cnt_q    <= '0;
        S_FINISH: last_cycles_q <= perf_cnt_q;
        default: begin
          if (perf_cnt_q != {PERF_W{1'b1}}) begin
            perf_cnt_q <= perf_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign last_frame_cycles = last_cycles_q;
`else
  assign last_frame_cycles = '0;
`endif

endmodule

// File: tb/tb_draw_frame_scheduler.sv
// Directed bench for draw_frame_scheduler with a small behavioural model of
// the four drawing clients (fixed done latency, optional stall/pixel).
module tb_draw_frame_scheduler;

  localparam int N   = 4;
  localparam int CW  = 11;
  localparam int TO  = 1000;
  localparam int DLY = 10;
`ifdef DRAW_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            tick;
  logic [N-1:0]    client_en;
  logic [N-1:0]    client_start;
  logic [N-1:0]    client_done;
  logic [N*CW-1:0] client_x;
  logic [N*CW-1:0] client_y;
  logic [N-1:0]    client_color;
  logic [N-1:0]    client_wr;
  logic [CW-1:0]   fb_x;
  logic [CW-1:0]   fb_y;
  logic            fb_color;
  logic            fb_write;
  logic            busy;
  logic            frame_done;
  logic            timeout_flag;
  logic [7:0]      dropped_ticks;
  logic [23:0]     last_frame_cycles;

  int errors = 0;
  int checks = 0;

  // Client model controls (written by the stimulus).
  logic [N-1:0]  stall;
  logic [N-1:0]  force_done;
  logic [N-1:0]  wr_const;
  logic [N-1:0]  pix_on_done;
  logic [CW-1:0] cx [N];
  logic [CW-1:0] cy [N];

  // Client model state and monitors (written by the model process).
  logic [N-1:0]  done_m;
  int            cnt [N];
  int            start_log [$];
  int            fd_cnt   = 0;
  int            busy_cyc = 0;
  int            wr_cnt   = 0;
  logic [CW-1:0] cap_x;
  logic [CW-1:0] cap_y;
  logic          cap_c;

  assign client_done = done_m | force_done;
  assign client_wr   = wr_const | (done_m & pix_on_done);

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign client_x[g*CW +: CW] = cx[g];
    assign client_y[g*CW +: CW] = cy[g];
  end

  draw_frame_scheduler #(
    .NUM_CLIENTS    (N),
    .COORD_W        (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .tick              (tick),
    .client_en         (client_en),
    .client_start      (client_start),
    .client_done       (client_done),
    .client_x          (client_x),
    .client_y          (client_y),
    .client_color      (client_color),
    .client_wr         (client_wr),
    .fb_x              (fb_x),
    .fb_y              (fb_y),
    .fb_color          (fb_color),
    .fb_write          (fb_write),
    .busy              (busy),
    .frame_done        (frame_done),
    .timeout_flag      (timeout_flag),
    .dropped_ticks     (dropped_ticks),
    .last_frame_cycles (last_frame_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Client behaviour and output monitors, evaluated mid-cycle.
  initial begin
    done_m = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (busy && !frame_done) busy_cyc++;
      if (frame_done) fd_cnt++;
      if (fb_write) begin
        wr_cnt++;
        cap_x = fb_x;
        cap_y = fb_y;
        cap_c = fb_color;
      end
      for (int i = 0; i < N; i++) begin
        done_m[i] = 1'b0;
        if (reset) begin
          cnt[i] = 0;
        end else if (client_start[i]) begin
          start_log.push_back(i);
          cnt[i] = stall[i] ? 0 : DLY;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) done_m[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Packs the start sequence since base as hex digits of (index+1).
  function automatic int order_code(input int base);
    int c = 0;
    for (int k = base; k < start_log.size(); k++) c = c * 16 + start_log[k] + 1;
    return c;
  endfunction

  task automatic tick_rise();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_frame(input int base, input int max_cyc, input string tag);
    int n = 0;
    while (fd_cnt == base && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(fd_cnt != base), 32'd1);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
    #1;
  endtask

  int b_log, b_fd, b_busy, b_wr, n_wait;

  initial begin
    reset        = 1'b1;
    tick         = 1'b0;
    client_en    = '0;
    client_color = '0;
    stall        = '0;
    force_done   = '0;
    wr_const     = '0;
    pix_on_done  = '0;
    for (int i = 0; i < N; i++) begin
      cx[i] = '0;
      cy[i] = '0;
    end

    // Reset state.
    settle(3);
    chk("rst_start",   32'(client_start),  32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_fdone",   32'(frame_done),    32'd0);
    chk("rst_fbwr",    32'(fb_write),      32'd0);
    chk("rst_fbx",     32'(fb_x),          32'd0);
    chk("rst_fby",     32'(fb_y),          32'd0);
    chk("rst_fbc",     32'(fb_color),      32'd0);
    chk("rst_tmo",     32'(timeout_flag),  32'd0);
    chk("rst_drop",    32'(dropped_ticks), 32'd0);
    chk("rst_perf",    32'(last_frame_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    settle(2);

    // A: all four clients, 12 busy cycles each (START + 10 WAIT + NEXT).
    client_en = 4'b1111;
    b_log = start_log.size(); b_fd = fd_cnt; b_busy = busy_cyc;
    tick_rise();
    wait_frame(b_fd, 200, "A_frame");
    settle(3);
    chk("A_order", 32'(order_code(b_log)), 32'h1234);
    chk("A_fdone_once", 32'(fd_cnt - b_fd), 32'd1);
    chk("A_busy_low", 32'(busy), 32'd0);
    chk("A_busy_cyc", 32'(busy_cyc - b_busy), 32'd48);
    chk("A_perf", 32'(last_frame_cycles), PERF ? 32'd48 : 32'd0);

    // B: clients 1 and 3 only; disabled client 0 spams pixels.
    client_en = 4'b1010;
    wr_const  = 4'b0001;
    cx[0]     = 11'd7;
    b_log = start_log.size(); b_fd = fd_cnt; b_busy = busy_cyc; b_wr = wr_cnt;
    tick_rise();
    wait_frame(b_fd, 200, "B_frame");
    settle(3);
    chk("B_order", 32'(order_code(b_log)), 32'h24);
    chk("B_no_leak", 32'(wr_cnt - b_wr), 32'd0);
    chk("B_busy_cyc", 32'(busy_cyc - b_busy), 32'd24);
    chk("B_perf", 32'(last_frame_cycles), PERF ? 32'd24 : 32'd0);
    wr_const = '0;

    // C: client 1 writes one pixel in its done cycle; client 0 holds a stray done.
    client_en    = 4'b0010;
    force_done   = 4'b0001;
    pix_on_done  = 4'b0010;
    cx[1]        = 11'd100;
    cy[1]        = 11'd50;
    client_color = 4'b0010;
    b_log = start_log.size(); b_fd = fd_cnt; b_busy = busy_cyc; b_wr = wr_cnt;
    tick_rise();
    wait_frame(b_fd, 200, "C_frame");
    settle(3);
    chk("C_order", 32'(order_code(b_log)), 32'h2);
    chk("C_wr_count", 32'(wr_cnt - b_wr), 32'd1);
    chk("C_fb_x", 32'(cap_x), 32'd100);
    chk("C_fb_y", 32'(cap_y), 32'd50);
    chk("C_fb_color", 32'(cap_c), 32'd1);
    chk("C_busy_cyc", 32'(busy_cyc - b_busy), 32'd12);
    force_done   = '0;
    pix_on_done  = '0;
    client_color = '0;

    // D: client 2 never finishes; watchdog fires after TO WAIT cycles.
    chk("D_tmo_before", 32'(timeout_flag), 32'd0);
    chk("D_drop_before", 32'(dropped_ticks), 32'd0);
    client_en = 4'b1100;
    stall     = 4'b0100;
    b_log = start_log.size(); b_fd = fd_cnt; b_busy = busy_cyc;
    tick_rise();
    wait_frame(b_fd, 1300, "D_frame");
    settle(3);
    chk("D_order", 32'(order_code(b_log)), 32'h34);
    chk("D_tmo_after", 32'(timeout_flag), 32'd1);
    chk("D_busy_cyc", 32'(busy_cyc - b_busy), 32'd1014);
    chk("D_fdone_once", 32'(fd_cnt - b_fd), 32'd1);

    // E: 300 extra rises while client 0 stalls; counter saturates, no restart.
    client_en = 4'b0001;
    stall     = 4'b0001;
    b_log = start_log.size(); b_fd = fd_cnt;
    tick_rise();
    for (int r = 0; r < 300; r++) tick_rise();
    #1;
    chk("E_drop_sat", 32'(dropped_ticks), 32'd255);
    chk("E_no_restart", 32'(order_code(b_log)), 32'h1);
    chk("E_still_busy", 32'(busy), 32'd1);
    wait_frame(b_fd, 1300, "E_frame");
    settle(3);
    chk("E_drop_hold", 32'(dropped_ticks), 32'd255);
    chk("E_tmo_sticky", 32'(timeout_flag), 32'd1);
    stall = '0;

    // F: reset while client 2 is streaming pixels, then a clean restart.
    client_en = 4'b1111;
    wr_const  = 4'b0100;
    cx[2]     = 11'd5;
    tick_rise();
    n_wait = 0;
    while (!client_start[2] && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    chk("F_reach_c2", 32'(client_start[2]), 32'd1);
    settle(3);
    chk("F_pre_fbwr", 32'(fb_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("F_rst_fbwr", 32'(fb_write), 32'd0);
    chk("F_rst_start", 32'(client_start), 32'd0);
    chk("F_rst_busy", 32'(busy), 32'd0);
    chk("F_rst_tmo", 32'(timeout_flag), 32'd0);
    chk("F_rst_drop", 32'(dropped_ticks), 32'd0);
    chk("F_rst_fbx", 32'(fb_x), 32'd0);
    settle(2);
    @(negedge clk);
    reset    = 1'b0;
    wr_const = '0;
    settle(2);
    b_log = start_log.size(); b_fd = fd_cnt; b_busy = busy_cyc;
    tick_rise();
    settle(2);
    chk("F_restart_cnt", 32'(start_log.size() - b_log), 32'd1);
    if (start_log.size() > b_log) chk("F_restart_idx", 32'(start_log[b_log]), 32'd0);
    wait_frame(b_fd, 200, "F_frame");
    settle(3);
    chk("F_order", 32'(order_code(b_log)), 32'h1234);
    chk("F_busy_cyc", 32'(busy_cyc - b_busy), 32'd48);
    chk("F_perf", 32'(last_frame_cycles), PERF ? 32'd48 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
